switch_ingress_fifo: RTL and testbench
======================================

Name: switch_ingress_fifo

Overview:
Per-source ingress buffer that sits directly upstream of the 4-port switch core. It stores {addr, data} words written by a source and acknowledges each accepted word on data_rcv. It presents the words in order to the switch routing logic, which pops them with rd_en. Four instances (one per source port) feed the core and drive its fifo_full/af/empty/ae status bits.

Parameters:
ADDR_W, 16, width of the routing address stored with each word
DATA_W, 16, payload width
DEPTH, 16, number of entries (power of two, >= 4)
AE_THRESH, 2, almost-empty asserted when count <= AE_THRESH
AF_THRESH, 14, almost-full asserted when count >= AF_THRESH

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
wr_en  in  1  push request from source
addr_in  in  ADDR_W  address of pushed word
data_in  in  DATA_W  payload of pushed word
data_rcv  out  1  one-cycle pulse: previous-cycle push accepted
rd_en  in  1  pop request from switch core
addr_out  out  ADDR_W  address of popped word
data_out  out  DATA_W  payload of popped word
rd_vld  out  1  addr_out/data_out valid this cycle
fifo_full  out  1  count == DEPTH
fifo_af  out  1  count >= AF_THRESH
fifo_empty  out  1  count == 0
fifo_ae  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy
ovf_err  out  1  sticky: push attempted while full and no pop
unf_err  out  1  sticky: pop attempted while empty
err_clr  in  1  synchronous clear of ovf_err/unf_err

Behaviour:
- Reset (async assert, any time, including mid-transfer): rd/wr pointers 0, count 0, fifo_empty=1, fifo_ae=1, fifo_full=0, fifo_af=0, data_rcv=0, rd_vld=0, addr_out=0, data_out=0, ovf_err=0, unf_err=0. Storage contents are don't-care. Deassertion takes effect at the next clk edge.
- Push accepted when wr_en && (!fifo_full || rd_en).
  - Word written at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
  - data_rcv=1 on the following cycle only; it is a registered pulse, one per accepted word.
- Pop accepted when rd_en && !fifo_empty.
  - Word at rd_ptr is registered onto addr_out/data_out with rd_vld=1 the next cycle; latency is 1.
  - rd_ptr increments modulo DEPTH.
  - Outputs hold their last value when rd_vld=0.
- Simultaneous push+pop:
  - Non-empty and non-full: both occur, count unchanged.
  - Full: pop frees a slot the same cycle, so the push is accepted, no ovf_err, count stays DEPTH.
  - Empty: push accepted, pop rejected, unf_err set, rd_vld=0 next cycle. There is no fall-through.
- count: +1 on push only, -1 on pop only, never exceeds DEPTH or goes below 0.
- Flags are registered and computed from next-count, so they change in the same cycle as count.
- Rejected push (full, no rd_en): no write, no data_rcv, ovf_err<=1.
- Rejected pop (empty): unf_err<=1, pointers unchanged.
- err_clr clears both sticky bits. If err_clr and a new error occur in the same cycle, the error wins (bit stays 1).
- Ordering is strict FIFO. addr and data of a word are never separated.

Test Plan:
- Reset then idle -> empty=1, ae=1, full=0, af=0, count=0, data_rcv=0, rd_vld=0, errors 0.
- Push 16 words (addr=i, data=16'hA000+i) back-to-back -> data_rcv pulses each cycle one cycle late; af rises when count=14; full=1 at count=16.
- Then push a 17th word with rd_en=0 -> no data_rcv, ovf_err=1, count stays 16.
- Pop 16 words -> rd_vld each following cycle with addr 0..15 / data A000..A00F in order; ae at count=2; empty at 0. Then pop once more -> unf_err=1, rd_vld=0.
- Full FIFO, wr_en and rd_en together for 20 cycles with incrementing data -> count stays 16, all pushes acknowledged, no ovf_err, output order preserved across pointer wrap.
- Empty FIFO, wr_en+rd_en same cycle -> push accepted, count=1, unf_err=1, rd_vld=0. Next cycle rd_en -> word appears. err_clr -> errors 0.
- Assert reset asynchronously (mid-cycle) with 8 words stored and a pop in flight -> outputs return to reset values immediately, no rd_vld afterwards, subsequent push/pop works from pointer 0.

Source files
------------

// File: rtl/switch_ingress_fifo.sv
// Per-source ingress FIFO feeding the switch core; 1-cycle pop latency, registered status flags.
// Backpressure: a push into a full FIFO is dropped (ovf_err) unless a pop frees the slot that cycle.
module switch_ingress_fifo #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int AE_THRESH = 2,
  parameter int AF_THRESH = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          addr_in,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       data_rcv,
  input  logic                       rd_en,
  output logic [ADDR_W-1:0]          addr_out,
  output logic [DATA_W-1:0]          data_out,
  output logic                       rd_vld,
  output logic                       fifo_full,
  output logic                       fifo_af,
  output logic                       fifo_empty,
  output logic                       fifo_ae,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf_err,
  output logic                       unf_err,
  input  logic                       err_clr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = ADDR_W + DATA_W;

  logic [WW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_nxt;

  // A pop on a full FIFO frees the slot the concurrent push lands in.
  assign push      = wr_en && (!fifo_full || rd_en);
  assign pop       = rd_en && !fifo_empty;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {addr_in, data_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
      fifo_af    <= 1'b0;
      fifo_empty <= 1'b1;
      fifo_ae    <= 1'b1;
      data_rcv   <= 1'b0;
      rd_vld     <= 1'b0;
      addr_out   <= '0;
      data_out   <= '0;
      ovf_err    <= 1'b0;
      unf_err    <= 1'b0;
    end else begin
      data_rcv <= push;
      rd_vld   <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr                <= rd_ptr + PW'(1);
        {addr_out, data_out}  <= mem[rd_ptr];
      end
      count      <= count_nxt;
      fifo_full  <= (count_nxt == CW'(DEPTH));
      fifo_af    <= (count_nxt >= CW'(AF_THRESH));
      fifo_empty <= (count_nxt == '0);
      fifo_ae    <= (count_nxt <= CW'(AE_THRESH));
      // A new error in the same cycle as err_clr keeps the sticky bit set.
      ovf_err <= (ovf_err && !err_clr) || (wr_en && fifo_full && !rd_en);
      unf_err <= (unf_err && !err_clr) || (rd_en && fifo_empty);
    end
  end
endmodule

// File: tb/tb_switch_ingress_fifo.sv
// Scoreboard bench for switch_ingress_fifo: queue-based reference model plus negedge monitor.
module tb_switch_ingress_fifo;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AE    = 2;
  localparam int AF    = 14;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] data_in = '0;
  logic          data_rcv, rd_vld, fifo_full, fifo_af, fifo_empty, fifo_ae;
  logic          ovf_err, unf_err;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_out;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  switch_ingress_fifo #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .AE_THRESH(AE), .AF_THRESH(AF)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .addr_in(addr_in), .data_in(data_in),
    .data_rcv(data_rcv), .rd_en(rd_en), .addr_out(addr_out), .data_out(data_out),
    .rd_vld(rd_vld), .fifo_full(fifo_full), .fifo_af(fifo_af), .fifo_empty(fifo_empty),
    .fifo_ae(fifo_ae), .count(count), .ovf_err(ovf_err), .unf_err(unf_err),
    .err_clr(err_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue of {addr,data} words.
  logic [31:0] q[$];
  logic [31:0] exp_q[$];
  bit m_rcv = 0, m_vld = 0, m_ovf = 0, m_unf = 0;

  always @(posedge clk or posedge reset) begin
    bit full, empty, do_push, do_pop;
    if (reset) begin
      q.delete();
      exp_q.delete();
      m_rcv = 0; m_vld = 0; m_ovf = 0; m_unf = 0;
    end else begin
      full    = (q.size() == DEPTH);
      empty   = (q.size() == 0);
      do_push = wr_en && (!full || rd_en);
      do_pop  = rd_en && !empty;
      if (do_pop) exp_q.push_back(q.pop_front());
      if (do_push) q.push_back({addr_in, data_in});
      m_rcv = do_push;
      m_vld = do_pop;
      if (err_clr) begin m_ovf = 0; m_unf = 0; end
      if (wr_en && full && !rd_en) m_ovf = 1;
      if (rd_en && empty) m_unf = 1;
    end
  end

  // Monitor: pops expected words whenever the DUT presents one.
  logic [31:0] last_word = '0;
  always @(negedge clk) begin
    int n;
    logic [31:0] w;
    if (reset) last_word = '0;
    n = q.size();
    chk("data_rcv", data_rcv, m_rcv);
    chk("rd_vld", rd_vld, m_vld);
    chk("count", count, n);
    chk("fifo_full", fifo_full, n == DEPTH);
    chk("fifo_af", fifo_af, n >= AF);
    chk("fifo_empty", fifo_empty, n == 0);
    chk("fifo_ae", fifo_ae, n <= AE);
    chk("ovf_err", ovf_err, m_ovf);
    chk("unf_err", unf_err, m_unf);
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h required=none at %0t", {addr_out, data_out}, $time);
      end else begin
        w = exp_q.pop_front();
        chk("word_out", {addr_out, data_out}, w);
        last_word = w;
      end
    end else begin
      chk("word_hold", {addr_out, data_out}, last_word);
    end
  end

  task automatic cyc(input bit w, input bit r, input logic [15:0] a, input logic [15:0] d,
                     input bit c);
    wr_en = w; rd_en = r; addr_in = a; data_in = d; err_clr = c;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] seq;
    int bias;
    seq = 16'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Fill, overflow, drain, underflow.
    for (int i = 0; i < 16; i++) cyc(1, 0, 16'(i), 16'hA000 + 16'(i), 0);
    cyc(1, 0, 16'h00FF, 16'hDEAD, 0);
    for (int i = 0; i < 17; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);

    // Full FIFO with simultaneous push+pop across pointer wrap.
    for (int i = 0; i < 16; i++) cyc(1, 0, 16'h100 + 16'(i), 16'hC000 + 16'(i), 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, 16'h200 + 16'(i), 16'hD000 + 16'(i), 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 0);

    // Empty FIFO push+pop: push taken, pop rejected, no fall-through.
    cyc(1, 1, 16'h0333, 16'h4444, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle with 8 words stored and a pop in flight.
    for (int i = 0; i < 8; i++) cyc(1, 0, 16'h300 + 16'(i), 16'hB000 + 16'(i), 0);
    wr_en = 0; rd_en = 1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_word", {addr_out, data_out}, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_ae", fifo_ae, 1);
    rd_en = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 16'h400 + 16'(i), 16'hE000 + 16'(i), 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);

    // Randomized traffic, alternating fill-biased and drain-biased phases.
    for (int blk = 0; blk < 10; blk++) begin
      bias = (blk % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 200; i++) begin
        seq = seq + 16'd1;
        cyc($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias - 10,
            16'($urandom), seq, $urandom_range(0, 15) == 0);
      end
    end

    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("model_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
